// File: rtl/cache_ptr_stack_pkg.sv
// cache_ptr_stack_pkg: command encoding and default pointer width for the cache pointer stack
package cache_ptr_stack_pkg;
  typedef enum logic [2:0] {CS_NOP, CS_PUSH, CS_POP, CS_REPLACE, CS_WRITE} cache_stack_cmd_t;
  localparam int CACHE_PTR_W = 8;
endpackage

// File: rtl/cache_ptr_stack_if.sv
// cache_ptr_stack_if: decoder/ALU side command bus and stack status outputs
interface cache_ptr_stack_if
  import cache_ptr_stack_pkg::*;
#(
  parameter int WIDTH = CACHE_PTR_W,
  parameter int DEPTH = 4
);
  logic                       push_en;
  logic                       pop_en;
  logic                       write_en;
  logic [WIDTH-1:0]           alu_result;
  logic [WIDTH-1:0]           cache_ptr;
  logic [$clog2(DEPTH+1)-1:0] depth;
  logic                       empty;
  logic                       full;
  logic                       err;
  modport master (output push_en, pop_en, write_en, alu_result, input cache_ptr, depth, empty, full, err);
  modport slave (input push_en, pop_en, write_en, alu_result, output cache_ptr, depth, empty, full, err);
endinterface

// File: rtl/cache_stack_mem.sv
// cache_stack_mem: unreset register array holding the older stack entries, one shared address
module cache_stack_mem #(
  parameter int WIDTH = 8,
  parameter int N     = 3,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [N];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/cache_ptr_stack.sv
// cache_ptr_stack: LIFO of cache pointers; define CACHE_PTR_STACK_ERR_EN for a sticky overflow/underflow err
module cache_ptr_stack
  import cache_ptr_stack_pkg::*;
#(
  parameter int WIDTH = CACHE_PTR_W,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  cache_ptr_stack_if.slave bus
);
  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH-1) : 1;
  function automatic cache_stack_cmd_t decode(logic push, logic pop, logic wr, logic emp);
    return (push && pop) ? (emp ? CS_PUSH : CS_REPLACE) :
           push          ? CS_PUSH :
           pop           ? CS_POP :
           wr            ? (emp ? CS_PUSH : CS_WRITE) : CS_NOP;
  endfunction
  cache_stack_cmd_t cmd;
  logic [WIDTH-1:0] top_q, top_d, rdata;
  logic [DW-1:0]    depth_q, depth_d;
  logic             empty_q, full_q, do_push, do_pop, mem_we;
  logic [AW-1:0]    mem_addr;
  always_comb begin
    cmd      = decode(bus.push_en, bus.pop_en, bus.write_en, empty_q);
    do_push  = (cmd == CS_PUSH) && !full_q;
    do_pop   = (cmd == CS_POP) && !empty_q;
    mem_we   = do_push && !empty_q;
    // push stores the old top at depth-1; pop reads the newest entry at depth-2
    mem_addr = AW'(do_push ? depth_q - DW'(1) : depth_q - DW'(2));
    top_d    = (do_push || cmd == CS_REPLACE || cmd == CS_WRITE) ? bus.alu_result :
               do_pop ? (depth_q == DW'(1) ? '0 : rdata) : top_q;
    depth_d  = do_push ? depth_q + DW'(1) : do_pop ? depth_q - DW'(1) : depth_q;
  end
  cache_stack_mem #(.WIDTH(WIDTH), .N(DEPTH-1), .AW(AW)) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(top_q),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      top_q   <= '0;
      depth_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      top_q   <= top_d;
      depth_q <= depth_d;
      empty_q <= depth_d == '0;
      full_q  <= depth_d == DW'(DEPTH);
    end
`ifdef CACHE_PTR_STACK_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_q || (cmd == CS_PUSH && full_q) || (cmd == CS_POP && empty_q);
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
  assign bus.cache_ptr = top_q;
  assign bus.depth     = depth_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
endmodule

// File: tb/tb_cache_ptr_stack.sv
// tb_cache_ptr_stack: directed vector table plus reset sequences for cache_ptr_stack (DEPTH=4, WIDTH=8)
module tb_cache_ptr_stack;
`ifdef CACHE_PTR_STACK_ERR_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif
  typedef struct {
    logic       push, pop, wr;
    logic [7:0] d;
    logic [7:0] ptr;
    logic [2:0] dep;
    logic       err;
    string      name;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t v[$];
  cache_ptr_stack_if #(.WIDTH(8), .DEPTH(4)) bus ();
  cache_ptr_stack #(.WIDTH(8), .DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic chk_state(string name, logic [7:0] ptr, logic [2:0] dep, logic err);
    chk({name, ".cache_ptr"}, 32'(bus.cache_ptr), 32'(ptr));
    chk({name, ".depth"}, 32'(bus.depth), 32'(dep));
    chk({name, ".empty"}, 32'(bus.empty), 32'(dep == 3'd0));
    chk({name, ".full"}, 32'(bus.full), 32'(dep == 3'd4));
    chk({name, ".err"}, 32'(bus.err), 32'(err));
  endtask
  task automatic drive(logic p, logic po, logic w, logic [7:0] d);
    bus.push_en = p;
    bus.pop_en = po;
    bus.write_en = w;
    bus.alu_result = d;
  endtask
  task automatic step(logic p, logic po, logic w, logic [7:0] d);
    drive(p, po, w, d);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 8'h00);
  endtask
  function automatic void add(string n, logic p, logic po, logic w, logic [7:0] d,
                              logic [7:0] ptr, logic [2:0] dep, logic err);
    vec_t x;
    x.push = p; x.pop = po; x.wr = w; x.d = d;
    x.ptr = ptr; x.dep = dep; x.err = err; x.name = n;
    v.push_back(x);
  endfunction
  initial begin
    add("write_empty", 0, 0, 1, 8'h5A, 8'h5A, 3'd1, 0);
    add("write_top",   0, 0, 1, 8'h11, 8'h11, 3'd1, 0);
    add("idle",        0, 0, 0, 8'h77, 8'h11, 3'd1, 0);
    add("pop_last",    0, 1, 0, 8'h00, 8'h00, 3'd0, 0);
    add("push1",       1, 0, 0, 8'h01, 8'h01, 3'd1, 0);
    add("push2",       1, 0, 0, 8'h02, 8'h02, 3'd2, 0);
    add("push3",       1, 0, 0, 8'h03, 8'h03, 3'd3, 0);
    add("push4",       1, 0, 0, 8'h04, 8'h04, 3'd4, 0);
    add("write_full",  0, 0, 1, 8'h44, 8'h44, 3'd4, 0);
    add("push_ovf",    1, 0, 0, 8'h05, 8'h44, 3'd4, E);
    add("pop1",        0, 1, 0, 8'h00, 8'h03, 3'd3, E);
    add("pop_wr",      0, 1, 1, 8'h99, 8'h02, 3'd2, E);
    add("pop3",        0, 1, 0, 8'h00, 8'h01, 3'd1, E);
    add("pop4",        0, 1, 0, 8'h00, 8'h00, 3'd0, E);
    add("pop_unf",     0, 1, 0, 8'h00, 8'h00, 3'd0, E);
    add("push10",      1, 0, 0, 8'h10, 8'h10, 3'd1, E);
    add("replace20",   1, 1, 0, 8'h20, 8'h20, 3'd1, E);
    add("replace30w",  1, 1, 1, 8'h30, 8'h30, 3'd1, E);
    add("push55",      1, 0, 0, 8'h55, 8'h55, 3'd2, E);
    add("replace66",   1, 1, 0, 8'h66, 8'h66, 3'd2, E);
    add("pop_keep",    0, 1, 0, 8'h00, 8'h30, 3'd1, E);
    add("pop_empty",   0, 1, 0, 8'h00, 8'h00, 3'd0, E);
    add("replace_emp", 1, 1, 0, 8'h44, 8'h44, 3'd1, E);
    drive(0, 0, 0, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_state("reset_idle", 8'h00, 3'd0, 0);
    foreach (v[i]) begin
      step(v[i].push, v[i].pop, v[i].wr, v[i].d);
      chk_state(v[i].name, v[i].ptr, v[i].dep, v[i].err);
    end
    // async reset landing between edges must clear outputs before the next edge
    step(1, 0, 0, 8'hAA);
    step(1, 0, 0, 8'hBB);
    chk_state("pre_reset", 8'hBB, 3'd3, E);
    #2 rst_n = 1'b0;
    #1 chk_state("async_reset", 8'h00, 3'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 8'hCC);
    chk_state("post_reset_push", 8'hCC, 3'd1, 0);
    step(0, 1, 0, 8'h00);
    chk_state("post_reset_pop", 8'h00, 3'd0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
